// File: rtl/msk_mc_pkg.sv
// msk_mc_pkg: shared FSM states, MixColumns coefficients and GF(2^8) helpers for msk_mixcolumns_seq
package msk_mc_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
  localparam logic [31:0] FWD_COEF = 32'h02030101;
  localparam logic [31:0] INV_COEF = 32'h0e0b0d09;
  localparam logic [7:0] GF_POLY = 8'h1b;
  function automatic int beats(input int lanes);
    return 4 / lanes;
  endfunction
  function automatic logic [7:0] coef(input logic inv, input int i);
    logic [31:0] m;
    m = inv ? INV_COEF : FWD_COEF;
    return m[31-8*i -: 8];
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] c);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = c[i] ? p ^ x : p;
      x = xtime(x);
    end
    return p;
  endfunction
endpackage

// File: rtl/msk_mc_lane.sv
// msk_mc_lane: combinational share-wise (Inv)MixColumns of one masked column
// Ports: col (4 masked bytes, 8*d bits each, bit k of share s at k*d+s), inverse (1 = InvMixColumns), res (same layout)
module msk_mc_lane
  import msk_mc_pkg::*;
#(
  parameter int d = 2
) (
  input  logic [32*d-1:0] col,
  input  logic            inverse,
  output logic [32*d-1:0] res
);
  for (genvar s = 0; s < d; s++) begin : g_s
    logic [31:0] bs;
    for (genvar r = 0; r < 4; r++) begin : g_r
      logic [7:0] o;
      assign o = gf_mul(bs[7:0],   coef(inverse, (4 - r) % 4)) ^
                 gf_mul(bs[15:8],  coef(inverse, (5 - r) % 4)) ^
                 gf_mul(bs[23:16], coef(inverse, (6 - r) % 4)) ^
                 gf_mul(bs[31:24], coef(inverse, (7 - r) % 4));
      for (genvar k = 0; k < 8; k++) begin : g_k
        assign bs[8*r+k] = col[r*8*d+k*d+s];
        assign res[r*8*d+k*d+s] = o[k];
      end
    end
  end
endmodule

// File: rtl/msk_mixcolumns_seq.sv
// msk_mixcolumns_seq: sequential masked AES (Inv)MixColumns, LANES columns per beat
// Ports: clk; rst_n (async, active-low); in_valid/in_ready/in_inverse/in_data input handshake;
//        out_valid/out_ready/out_data result handshake. 128*d-bit states, byte b at [8*d*b +: 8*d],
//        bit k of share s at k*d+s. Build macro MSK_MC_CLEAR_EN zeroizes the buffer once the result is consumed.
module msk_mixcolumns_seq
  import msk_mc_pkg::*;
#(
  parameter int d = 2,
  parameter int LANES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_inverse,
  input  logic [128*d-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [128*d-1:0] out_data
);
  localparam int CW = 32 * d;
  localparam int BEATS = beats(LANES);
  if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
    $error("LANES must be 1, 2 or 4");
  end
  state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic mode_q, mode_n;
  logic [128*d-1:0] st, st_n;
  logic [1:0] idx [LANES];
  logic [CW-1:0] lane_in [LANES];
  logic [CW-1:0] lane_out [LANES];
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign idx[l] = 2'(int'(cnt) * LANES + l);
    assign lane_in[l] = st[int'(idx[l])*CW +: CW];
    msk_mc_lane #(.d(d)) u_lane (.col(lane_in[l]), .inverse(mode_q), .res(lane_out[l]));
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    mode_n = mode_q;
    st_n = st;
    in_ready = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_n = BUSY;
          cnt_n = '0;
          mode_n = in_inverse;
          st_n = in_data;
        end
      end
      BUSY: begin
        for (int l = 0; l < LANES; l++) st_n[int'(idx[l])*CW +: CW] = lane_out[l];
        cnt_n = cnt + 2'd1;
        if (cnt == 2'(BEATS - 1)) begin
          state_n = DONE;
          cnt_n = '0;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_n = IDLE;
`ifdef MSK_MC_CLEAR_EN
          st_n = '0;
`else
          st_n = st;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      mode_q <= 1'b0;
      st <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      mode_q <= mode_n;
      st <= st_n;
    end
  end
  assign out_data = st;
endmodule

// File: tb/tb_msk_mixcolumns_seq.sv
// tb_msk_mixcolumns_seq: vector, random and corner-case checks of msk_mixcolumns_seq with LANES=1 and LANES=4
module tb_msk_mixcolumns_seq;
  localparam int D = 2;
  localparam int DW = 128 * D;
  typedef struct {
    int u;
    logic inv;
    logic [127:0] in_h;
    logic [127:0] exp_h;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n;
  logic iv [2];
  logic ir [2];
  logic inv [2];
  logic [DW-1:0] idata [2];
  logic ov [2];
  logic ordy [2];
  logic [DW-1:0] odata [2];
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  msk_mixcolumns_seq #(.d(D), .LANES(1)) u_l1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_inverse(inv[0]),
    .in_data(idata[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0])
  );
  msk_mixcolumns_seq #(.d(D), .LANES(4)) u_l4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_inverse(inv[1]),
    .in_data(idata[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1])
  );
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
    end
    return p;
  endfunction
  function automatic logic [127:0] mc_ref(input logic [127:0] p, input logic inv_b);
    logic [7:0] m [4];
    logic [127:0] q;
    logic [7:0] acc;
    if (inv_b) m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else m = '{8'h02, 8'h03, 8'h01, 8'h01};
    q = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int j = 0; j < 4; j++) acc ^= gmul(p[8*(4*c+j) +: 8], m[(j - r + 4) % 4]);
        q[8*(4*c+r) +: 8] = acc;
      end
    return q;
  endfunction
  function automatic logic [127:0] from_hex(input logic [127:0] h);
    logic [127:0] p;
    for (int b = 0; b < 16; b++) p[8*b +: 8] = h[127-8*b -: 8];
    return p;
  endfunction
  function automatic logic [DW-1:0] mask(input logic [127:0] p);
    logic [DW-1:0] m;
    logic x, r;
    m = '0;
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 8; k++) begin
        x = p[8*b+k];
        for (int s = 1; s < D; s++) begin
          r = 1'($urandom_range(0, 1));
          m[8*D*b+k*D+s] = r;
          x ^= r;
        end
        m[8*D*b+k*D] = x;
      end
    return m;
  endfunction
  function automatic logic [127:0] unmask(input logic [DW-1:0] m);
    logic [127:0] p;
    logic x;
    for (int b = 0; b < 16; b++)
      for (int k = 0; k < 8; k++) begin
        x = 1'b0;
        for (int s = 0; s < D; s++) x ^= m[8*D*b+k*D+s];
        p[8*b+k] = x;
      end
    return p;
  endfunction
  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction
  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic run(input int u, input logic [DW-1:0] data, input logic inv_b,
                     output logic [DW-1:0] res, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!ir[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ir[u]) chk("in_ready_timeout", 0, 1);
    idata[u] = data;
    inv[u] = inv_b;
    iv[u] = 1'b1;
    @(posedge clk);
    #1;
    iv[u] = 1'b0;
    inv[u] = ~inv_b;
    idata[u] = {8{$urandom}};
    lat = 1;
    while (!ov[u] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = odata[u];
    @(posedge clk);
    #1;
  endtask
  vec_t tv [8];
  logic [DW-1:0] res, r1, r2, m1, hold, s0m, s1m;
  logic [127:0] pa, pb;
  logic ib;
  int lat, u;
  initial begin
    tv[0] = '{0, 1'b0, 128'hdb135345_00000000_00000000_00000000, 128'h8e4da1bc_00000000_00000000_00000000};
    tv[1] = '{0, 1'b1, 128'h8e4da1bc_00000000_00000000_00000000, 128'hdb135345_00000000_00000000_00000000};
    tv[2] = '{0, 1'b0, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101};
    tv[3] = '{0, 1'b1, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101, 128'hc6c6c6c6_01010101_c6c6c6c6_01010101};
    tv[4] = '{1, 1'b0, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5, 128'h046681e5_e0cb199a_48f8d37a_2806264c};
    tv[5] = '{1, 1'b1, 128'h046681e5_e0cb199a_48f8d37a_2806264c, 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5};
    tv[6] = '{1, 1'b0, 128'h00000000_00000000_db135345_00000000, 128'h00000000_00000000_8e4da1bc_00000000};
    tv[7] = '{0, 1'b0, 128'h00000000_00000000_00000000_db135345, 128'h00000000_00000000_00000000_8e4da1bc};
    for (int i = 0; i < 2; i++) begin
      iv[i] = 1'b0;
      inv[i] = 1'b0;
      idata[i] = '0;
      ordy[i] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) chk("reset_state", {ov[i], ir[i], odata[i]}, {1'b0, 1'b1, {DW{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      run(tv[i].u, mask(from_hex(tv[i].in_h)), tv[i].inv, res, lat);
      chk("vec_data", unmask(res), from_hex(tv[i].exp_h));
      chk("vec_latency", lat, tv[i].u == 0 ? 5 : 2);
    end
    for (int i = 0; i < 16; i++) begin
      u = i % 2;
      pa = rnd128();
      ib = 1'($urandom_range(0, 1));
      run(u, mask(pa), ib, res, lat);
      chk("rand_data", unmask(res), mc_ref(pa, ib));
      chk("rand_latency", lat, u == 0 ? 5 : 2);
    end
    pa = rnd128();
    pb = rnd128();
    @(negedge clk);
    ordy[0] = 1'b0;
    idata[0] = mask(pa);
    inv[0] = 1'b0;
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_latency", lat, 5);
    hold = odata[0];
    chk("bp_result", unmask(hold), mc_ref(pa, 1'b0));
    idata[0] = mask(pb);
    inv[0] = 1'b1;
    iv[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp_stable", {ov[0], ir[0], odata[0]}, {1'b1, 1'b0, hold});
    end
    ordy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {ov[0], ir[0]}, 2'b01);
    @(posedge clk);
    #1;
    chk("bp_accept", ir[0], 1'b0);
    iv[0] = 1'b0;
    lat = 1;
    while (!ov[0] && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("bp_second_latency", lat, 5);
    chk("bp_second_data", unmask(odata[0]), mc_ref(pb, 1'b1));
    @(posedge clk);
    #1;
    pa = rnd128();
    @(negedge clk);
    idata[0] = mask(pa);
    iv[0] = 1'b1;
    @(posedge clk);
    #1;
    iv[0] = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {ov[0], ir[0], odata[0]}, {1'b0, 1'b1, {DW{1'b0}}});
    @(negedge clk);
    rst_n = 1'b1;
    pa = rnd128();
    run(0, mask(pa), 1'b1, res, lat);
    chk("after_reset_data", unmask(res), mc_ref(pa, 1'b1));
    chk("after_reset_latency", lat, 5);
    s0m = '0;
    s1m = '0;
    for (int b = 0; b < DW; b++) begin
      if (b % D == 0) s0m[b] = 1'b1;
      if (b % D == 1) s1m[b] = 1'b1;
    end
    pa = rnd128();
    m1 = mask(pa);
    run(0, m1, 1'b0, r1, lat);
    run(0, m1 ^ s1m, 1'b0, r2, lat);
    chk("share0_unchanged", (r1 ^ r2) & s0m, '0);
    chk("share1_changes", ((r1 ^ r2) & s1m) != '0, 1'b1);
    chk("share_flip_data", unmask(r2), mc_ref(~pa, 1'b0));
`ifdef MSK_MC_CLEAR_EN
    chk("idle_cleared", odata[0], '0);
`else
    chk("idle_retained", odata[0], r2);
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
